// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- EX-stage multiply/accumulate controller.
//
// Owns the architectural HI/LO pair and sequences an external multi-cycle
// signed multiplier. Unsigned variants are produced from the signed product
// by adding a high-half correction; accumulate/subtract is folded in when the
// result is retired.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   req_valid/op/a/b    EX-stage request (op: 1 MULT 2 MULTU 3 MADD 4 MADDU
//                       5 MSUB 6 MSUBU 7 LOAD HI<=a LO<=b, 0 none)
//   flush               synchronous kill of the in-flight op
//   stall               hold the EX stage
//   done                one-cycle pulse on the cycle HI/LO are written
//   hi, lo              architectural HI/LO
//   mul_en/ready/flush  multiplier control
//   mul_a, mul_b        latched operands, stable for the whole op
//   mul_busy, mul_out   multiplier status and signed 64-bit product
//
// state  | meaning
// IDLE   | no op in flight; accepts multiply ops, executes LOAD directly
// START  | multiplier captures operands at the end of this cycle
// WAIT   | multiplier running, leave on the first cycle mul_busy is low
// FIN    | product valid; HI/LO written at the end of this cycle
module mdu_ctrl #(
    parameter logic [63:0] HILO_RST = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mul_en,
    output logic        mul_ready,
    output logic        mul_flush,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_busy,
    input  logic [63:0] mul_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [2:0]  op_q, op_d;
    logic [63:0] hilo_q, hilo_d;

    logic        req_mul, req_load, accept;
    logic        op_unsigned;
    logic [31:0] corr_hi;
    logic [63:0] prod, result;

    assign req_mul  = req_valid && (req_op != 3'b000) && (req_op != 3'b111);
    assign req_load = req_valid && (req_op == 3'b111);
    assign accept   = (state_q == S_IDLE) && req_mul && !flush;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            opa_q   <= 32'h0;
            opb_q   <= 32'h0;
            op_q    <= 3'b000;
            hilo_q  <= HILO_RST;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            op_q    <= op_d;
            hilo_q  <= hilo_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (req_mul) state_d = S_START;
                S_START: state_d = S_WAIT;
                S_WAIT:  if (!mul_busy) state_d = S_FIN;
                S_FIN:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Result path. The multiplier is signed only; reading an operand as
    // unsigned adds 2^32 * (other operand) when its sign bit is set, and only
    // the low 32 bits of that sum survive the shift into the high half.
    always_comb begin
        op_unsigned = (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
        corr_hi     = ({32{opa_q[31]}} & opb_q) + ({32{opb_q[31]}} & opa_q);
        prod        = op_unsigned ? (mul_out + {corr_hi, 32'h0}) : mul_out;
        case (op_q)
            3'b001, 3'b010: result = prod;
            3'b011, 3'b100: result = hilo_q + prod;
            3'b101, 3'b110: result = hilo_q - prod;
            default:        result = hilo_q;
        endcase
    end

    always_comb begin
        opa_d  = opa_q;
        opb_d  = opb_q;
        op_d   = op_q;
        hilo_d = hilo_q;
        if (accept) begin
            opa_d = req_a;
            opb_d = req_b;
            op_d  = req_op;
        end
        if (!flush) begin
            if (state_q == S_IDLE && req_load) begin
                hilo_d = {req_a, req_b};
            end else if (state_q == S_FIN) begin
                hilo_d = result;
            end
        end
    end

    // Outputs
    always_comb begin
        stall     = 1'b0;
        done      = 1'b0;
        mul_en    = 1'b0;
        mul_ready = 1'b1;
        case (state_q)
            S_IDLE: begin
                stall = req_mul;
                done  = req_load && !flush;
            end
            S_START: begin
                stall     = 1'b1;
                mul_en    = 1'b1;
                mul_ready = 1'b0;
            end
            S_WAIT:  stall = 1'b1;
            S_FIN:   done  = !flush;
            default: ;
        endcase
    end

    assign mul_flush = flush;
    assign mul_a     = opa_q;
    assign mul_b     = opb_q;
    assign hi        = hilo_q[63:32];
    assign lo        = hilo_q[31:0];

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = 3'b000;
    logic [31:0] req_a = 32'h0;
    logic [31:0] req_b = 32'h0;
    logic        flush = 1'b0;
    logic        stall, done, mul_en, mul_ready, mul_flush, mul_busy;
    logic [31:0] hi, lo, mul_a, mul_b;
    logic [63:0] mul_out;

    int total = 0;
    int bad   = 0;
    logic [63:0] model_hilo = 64'h0;

    always #5 clk = ~clk;

    mdu_ctrl #(.HILO_RST(64'h0)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .flush(flush), .stall(stall),
        .done(done), .hi(hi), .lo(lo), .mul_en(mul_en),
        .mul_ready(mul_ready), .mul_flush(mul_flush), .mul_a(mul_a),
        .mul_b(mul_b), .mul_busy(mul_busy), .mul_out(mul_out)
    );

    // Multiplier stand-in: busy for five cycles after capture, product held.
    logic [2:0]  mcnt;
    logic [63:0] mprod;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcnt  <= 3'd0;
            mprod <= 64'h0;
        end else if (mul_flush) begin
            mcnt <= 3'd0;
        end else if (mul_en) begin
            mcnt  <= 3'd5;
            mprod <= {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
        end else if (mcnt != 3'd0) begin
            mcnt <= mcnt - 3'd1;
        end
    end
    assign mul_busy = (mcnt != 3'd0);
    assign mul_out  = mprod;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: architectural meaning of each op on {HI,LO}.
    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] acc);
        logic signed [63:0] ps;
        logic [63:0] pu;
        ps = 64'($signed(a)) * 64'($signed(b));
        pu = {32'h0, a} * {32'h0, b};
        case (op)
            3'd1: return ps;
            3'd2: return pu;
            3'd3: return acc + ps;
            3'd4: return acc + pu;
            3'd5: return acc - ps;
            3'd6: return acc - pu;
            3'd7: return {a, b};
            default: return acc;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1; req_op = 3'd7; req_a = a; req_b = b;
        #1;
        check("load_done", 64'(done), 64'd1);
        check("load_stall", 64'(stall), 64'd0);
        tick();
        req_valid = 1'b0; req_op = 3'd0;
        #1;
        model_hilo = {a, b};
        check("load_hilo", {hi, lo}, model_hilo);
        check("load_done_clr", 64'(done), 64'd0);
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        lat = 0;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        #1;
        check("acc_stall", 64'(stall), 64'd1);
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            tick();
            req_valid = 1'b0; req_op = 3'd0;
            #1;
            if (done) begin
                lat = i;
                check("fin_stall", 64'(stall), 64'd0);
            end else begin
                check("busy_stall", 64'(stall), 64'd1);
            end
        end
        check("latency", 64'(lat), 64'd8);
        tick();
        model_hilo = ref_op(op, a, b, model_hilo);
        check("op_hilo", {hi, lo}, model_hilo);
        check("post_stall", 64'(stall), 64'd0);
    endtask

    initial begin
        int n17;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        #12;
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_ready", 64'(mul_ready), 64'd1);
        check("rst_hilo", {hi, lo}, 64'h0);
        rst = 1'b1;
        tick();
        check("rst_done", 64'(done), 64'd0);
        check("rst_mul_en", 64'(mul_en), 64'd0);

        // Directed cases from the block's intended use
        do_op(3'd1, 32'hFFFF_FFFD, 32'd5);
        check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2);
        check("multu", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2);
        check("mult_m1", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        do_load(32'h0, 32'h10);
        do_op(3'd3, 32'd3, 32'd4);
        check("madd", {hi, lo}, 64'h0000_0000_0000_001C);
        do_load(32'h0, 32'h0);
        do_op(3'd6, 32'd1, 32'd1);
        check("msubu", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);

        // Flush in WAIT: no write, no done
        req_valid = 1'b1; req_op = 3'd1; req_a = 32'd9; req_b = 32'd9;
        tick();
        req_valid = 1'b0; req_op = 3'd0;
        tick(); tick(); tick();
        flush = 1'b1;
        #1;
        check("flush_mul", 64'(mul_flush), 64'd1);
        check("flush_done", 64'(done), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_stall", 64'(stall), 64'd0);
        n17 = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) n17++;
            tick();
        end
        check("flush_nodone", 64'(n17), 64'd0);
        check("flush_hilo", {hi, lo}, model_hilo);

        // Flush in FIN suppresses the write
        req_valid = 1'b1; req_op = 3'd1; req_a = 32'd3; req_b = 32'd3;
        tick();
        req_valid = 1'b0; req_op = 3'd0;
        for (int i = 0; i < 7; i++) tick();
        flush = 1'b1;
        #1;
        check("finflush_done", 64'(done), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        check("finflush_hilo", {hi, lo}, model_hilo);

        // Request coinciding with flush is dropped
        req_valid = 1'b1; req_op = 3'd1; flush = 1'b1;
        tick();
        req_valid = 1'b0; req_op = 3'd0; flush = 1'b0;
        #1;
        check("drop_stall", 64'(stall), 64'd0);
        check("drop_mul_en", 64'(mul_en), 64'd0);

        // Async reset in WAIT
        req_valid = 1'b1; req_op = 3'd1; req_a = 32'd5; req_b = 32'd5;
        tick();
        req_valid = 1'b0; req_op = 3'd0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("arst_stall", 64'(stall), 64'd0);
        check("arst_hilo", {hi, lo}, 64'h0);
        check("arst_ready", 64'(mul_ready), 64'd1);
        model_hilo = 64'h0;
        tick();
        rst = 1'b1;
        tick();
        do_op(3'd1, 32'd7, 32'd6);
        check("arst_mult", 64'(lo), 64'h2A);

        // Back-to-back with req_valid held
        req_valid = 1'b1; req_op = 3'd1; req_a = 32'd11; req_b = 32'hFFFF_FFFE;
        n17 = 0;
        for (int c = 0; c <= 17; c++) begin
            #1;
            if (c == 8 || c == 17) check("b2b_done", 64'(done), 64'd1);
            else if (done) n17++;
            if (c == 8) check("b2b_fin_stall", 64'(stall), 64'd0);
            if (c == 9) check("b2b_reacc", 64'(stall), 64'd1);
            if (c == 17) begin req_valid = 1'b0; req_op = 3'd0; end
            if (c < 17) tick();
        end
        check("b2b_extra_done", 64'(n17), 64'd0);
        tick();
        model_hilo = ref_op(3'd1, 32'd11, 32'hFFFF_FFFE, model_hilo);
        check("b2b_hilo", {hi, lo}, model_hilo);

        // Randomized ops against the reference
        for (int k = 0; k < 24; k++) begin
            rop = 3'($urandom_range(1, 7));
            ra  = $urandom;
            rb  = $urandom;
            if (k % 6 == 0) ra = 32'h8000_0000;
            if (k % 6 == 1) rb = 32'hFFFF_FFFF;
            if (rop == 3'd7) do_load(ra, rb);
            else do_op(rop, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multiply/accumulate controller in the EX stage. It owns the architectural HI/LO registers and sequences the shared 6-stage signed Booth/CSA multiplier datapath. It accepts MULT/MULTU/MADD/MADDU/MSUB/MSUBU and a direct HI/LO load. It stalls the pipeline until the result is retired, applies the unsigned correction and the accumulate/subtract, and honours pipeline flush.

Parameters:
HILO_RST, 64'h0, reset value of {HI,LO}

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  EX-stage instruction needs the MDU
req_op  in  3  001 MULT, 010 MULTU, 011 MADD, 100 MADDU, 101 MSUB, 110 MSUBU, 111 LOAD (HI<=a, LO<=b), 000 none
req_a  in  32  rs operand
req_b  in  32  rt operand
flush  in  1  synchronous kill of the in-flight op
stall  out  1  hold EX stage
done  out  1  one-cycle pulse on the cycle HI/LO are written
hi  out  32  HI register
lo  out  32  LO register
mul_en  out  1  multiplier operand capture/start
mul_ready  out  1  multiplier start suppress; 0 only in START
mul_flush  out  1  equals flush, clears multiplier counter
mul_a  out  32  latched operand a, stable for the whole op
mul_b  out  32  latched operand b, stable for the whole op
mul_busy  in  1  multiplier counter non-zero
mul_out  in  64  signed product, valid when mul_busy falls

Behaviour:
- Reset (rst=0, async): state=IDLE, {hi,lo}=HILO_RST, opa/opb/op latches=0, done=0, stall=0, mul_en=0, mul_ready=1.
- States: IDLE, START, WAIT, FIN (2-bit register).
- IDLE + req_valid + op in 001..110 + !flush: latch a, b, op; go to START. stall=1 combinationally in this cycle.
- IDLE + op 111: HI<=a, LO<=b at the edge; done=1 that cycle; stall=0; stays IDLE.
- START: mul_en=1, mul_ready=0; go to WAIT. The multiplier captures operands at this edge.
- WAIT: mul_en=0. Stay while mul_busy=1. Go to FIN on the first cycle mul_busy=0.
- FIN: compute the result and write {HI,LO} at the edge; done=1; go to IDLE.
  - stall=0 in FIN, so the instruction leaves EX at the end of FIN. req_valid is ignored in FIN.
- stall = (IDLE & req_valid & op in 001..110) | START | WAIT.
- Latency: accept at cycle T, START T+1, WAIT T+2..T+7, FIN T+8. New hi/lo visible at T+9.
- Unsigned correction, all mod 2^64: P = mul_out + ((a[31]?b:0) << 32) + ((b[31]?a:0) << 32).
  - Applied for MULTU, MADDU, MSUBU only.
  - Signed ops use P = mul_out.
- Result:
  - MULT/MULTU: {HI,LO} = P.
  - MADD/MADDU: {HI,LO} + P.
  - MSUB/MSUBU: {HI,LO} − P.
  - All 64-bit, wrap-around, no overflow flag.
- Flush (any state, highest priority): go to IDLE next edge; mul_flush=1; no HI/LO write; done=0.
  - A request arriving in the same cycle as flush is dropped.
  - Flush in FIN suppresses the write.
- Async reset mid-operation: immediate IDLE. The multiplier is flushed by the top-level reset.
- Back-to-back requests: the next request is accepted earliest at T+9 (IDLE). No overlap.

Test Plan:
- MULT a=0xFFFFFFFD, b=5 -> stall high T..T+7, done at T+8; hi=0xFFFFFFFF, lo=0xFFFFFFF1 at T+9.
- MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE; same op as MULT -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- LOAD a=0, b=0x10, then MADD a=3, b=4 -> hi=0, lo=0x1C. Then MSUBU a=1, b=1 from {0,0} -> hi=lo=0xFFFFFFFF.
- MULT issued, flush at T+4 -> mul_flush=1, state IDLE at T+5, stall low, done never pulses, hi/lo unchanged.
- rst low during WAIT -> outputs at reset values immediately; after release, MULT 7*6 gives lo=0x2A.
- Two MULTs back-to-back with req_valid held -> second accepted exactly at T+9, done pulses at T+8 and T+17.
